// File: rtl/usb_line_encoder.sv
// -----------------------------------------------------------------------------
// usb_line_encoder
//
// USB transmit line encoder. Takes a serial payload bit stream (LSB first)
// over a valid/ready handshake and drives registered D+/D- with NRZI coding,
// automatic bit stuffing, an internal bit-period timer and a self-timed EOP.
//
// Line model: every state decides one line symbol at its bit strobe, and that
// symbol is registered on the edge ending the strobe cycle. It is then held
// for exactly CLKS_PER_BIT cycles.
//   - The last data bit, or the stuffed bit after it, is followed by
//     EOP_SE0_BITS symbols of SE0.
//   - A J symbol follows the SE0. The encoder stays busy until that J has
//     lasted a full bit time.
//   - On a payload underrun, the strobe that finds no data already drives the
//     first SE0 symbol. In that case EOP_SE0 starts with one SE0 bit done.
//
// Optional feature (macro USB_ENC_SYNC_GEN_EN):
//   - Defined: a SYNC pattern (KJKJKJKK) is generated before the payload.
//   - Undefined: the upstream block supplies SYNC as payload.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per USB bit time (>= 1)
//   STUFF_LIMIT   consecutive ones after which a stuffed 0 is inserted
//   EOP_SE0_BITS  SE0 length of EOP in bit times (>= 1)
//   LOW_SPEED     0: J = (D+=1, D-=0); 1: J = (D+=0, D-=1)
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tx_bit       payload bit
//   tx_valid     tx_bit valid; in IDLE starts a packet
//   tx_last      marks tx_bit as the final payload bit
//   tx_ready     combinational, bit consumed this cycle
//   tx_underrun  one-cycle pulse, payload starved mid-packet
//   busy         high whenever the encoder is not idle
//   dplus_out    registered D+
//   dminus_out   registered D-
// -----------------------------------------------------------------------------
module usb_line_encoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int STUFF_LIMIT  = 6,
    parameter int EOP_SE0_BITS = 2,
    parameter bit LOW_SPEED    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tx_bit,
    input  logic tx_valid,
    input  logic tx_last,
    output logic tx_ready,
    output logic tx_underrun,
    output logic busy,
    output logic dplus_out,
    output logic dminus_out
);

    localparam int CNT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam int AUX_W  = ($clog2(EOP_SE0_BITS + 1) > 3) ? $clog2(EOP_SE0_BITS + 1) : 3;

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ONES_W-1:0] ONES_LIM = ONES_W'(STUFF_LIMIT);
    localparam logic [AUX_W-1:0]  SE0_LAST = AUX_W'(EOP_SE0_BITS - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_STUFF   = 3'd3;
    localparam logic [2:0] ST_EOP_SE0 = 3'd4;
    localparam logic [2:0] ST_EOP_J   = 3'd5;
`ifdef USB_ENC_SYNC_GEN_EN
    localparam logic [2:0]       ST_SYNC   = 3'd1;
    localparam logic [AUX_W-1:0] SYNC_LAST = AUX_W'(7);
`endif

    // Line pair {D+, D-} for a differential level (1 = J, 0 = K).
    function automatic logic [1:0] nrzi_sym(input logic level);
        logic dp;
        dp = level ^ LOW_SPEED;
        return {dp, ~dp};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ONES_W-1:0] ones_q, ones_d;
    logic [AUX_W-1:0]  aux_q, aux_d;     // SYNC bit index / SE0 count / J phase
    logic              level_q, level_d; // NRZI level, 1 = J
    logic [1:0]        line_q, line_d;   // registered {D+, D-}
    logic              strobe_s;
    logic              ready_s;
    logic              underrun_s;
    logic              bit_level_s;
    logic [ONES_W-1:0] bit_ones_s;

    assign strobe_s = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);

    // Effect of consuming tx_bit: a 0 toggles the level and clears the run of ones.
    assign bit_level_s = tx_bit ? level_q : ~level_q;
    assign bit_ones_s  = tx_bit ? (ones_q + ONES_W'(1)) : {ONES_W{1'b0}};

    // Next-state, line symbol and handshake decode.
    always_comb begin
        state_d    = state_q;
        ones_d     = ones_q;
        aux_d      = aux_q;
        level_d    = level_q;
        line_d     = line_q;
        ready_s    = 1'b0;
        underrun_s = 1'b0;

        if (state_q == ST_IDLE) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (strobe_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                ones_d  = {ONES_W{1'b0}};
                aux_d   = {AUX_W{1'b0}};
                level_d = 1'b1;
                line_d  = nrzi_sym(1'b1);
                if (tx_valid) begin
`ifdef USB_ENC_SYNC_GEN_EN
                    state_d = ST_SYNC;
`else
                    state_d = ST_DATA;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
`ifdef USB_ENC_SYNC_GEN_EN
            // Seven zeros (toggles) then a one (hold); the closing one seeds the run.
            ST_SYNC: begin
                if (strobe_s) begin
                    if (aux_q == SYNC_LAST) begin
                        ones_d  = ONES_W'(1);
                        aux_d   = {AUX_W{1'b0}};
                        state_d = ST_DATA;
                    end else begin
                        level_d = ~level_q;
                        aux_d   = aux_q + AUX_W'(1);
                    end
                    line_d = nrzi_sym(aux_q == SYNC_LAST ? level_q : ~level_q);
                end else begin
                    state_d = ST_SYNC;
                end
            end
`endif
            ST_DATA: begin
                if (!strobe_s) begin
                    state_d = ST_DATA;
                end else if (ones_q == ONES_LIM) begin
                    // Stuffed zero takes priority; the pending bit waits.
                    level_d = ~level_q;
                    ones_d  = {ONES_W{1'b0}};
                    line_d  = nrzi_sym(~level_q);
                end else if (tx_valid) begin
                    ready_s = 1'b1;
                    level_d = bit_level_s;
                    ones_d  = bit_ones_s;
                    line_d  = nrzi_sym(bit_level_s);
                    if (!tx_last) begin
                        state_d = ST_DATA;
                    end else if (bit_ones_s == ONES_LIM) begin
                        state_d = ST_STUFF;
                    end else begin
                        state_d = ST_EOP_SE0;
                        aux_d   = {AUX_W{1'b0}};
                    end
                end else begin
                    // Starved: this strobe already drives the first SE0 bit.
                    underrun_s = 1'b1;
                    line_d     = 2'b00;
                    if (EOP_SE0_BITS == 1) begin
                        state_d = ST_EOP_J;
                        aux_d   = {AUX_W{1'b0}};
                    end else begin
                        state_d = ST_EOP_SE0;
                        aux_d   = AUX_W'(1);
                    end
                end
            end
            ST_STUFF: begin
                if (strobe_s) begin
                    level_d = ~level_q;
                    ones_d  = {ONES_W{1'b0}};
                    line_d  = nrzi_sym(~level_q);
                    aux_d   = {AUX_W{1'b0}};
                    state_d = ST_EOP_SE0;
                end else begin
                    state_d = ST_STUFF;
                end
            end
            ST_EOP_SE0: begin
                if (strobe_s) begin
                    line_d = 2'b00;
                    if (aux_q == SE0_LAST) begin
                        aux_d   = {AUX_W{1'b0}};
                        state_d = ST_EOP_J;
                    end else begin
                        aux_d = aux_q + AUX_W'(1);
                    end
                end else begin
                    state_d = ST_EOP_SE0;
                end
            end
            // First strobe drives J; the second ends that J bit time.
            ST_EOP_J: begin
                if (!strobe_s) begin
                    state_d = ST_EOP_J;
                end else if (aux_q == {AUX_W{1'b0}}) begin
                    level_d = 1'b1;
                    line_d  = nrzi_sym(1'b1);
                    aux_d   = AUX_W'(1);
                end else begin
                    aux_d   = {AUX_W{1'b0}};
                    ones_d  = {ONES_W{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ones_d  = {ONES_W{1'b0}};
                aux_d   = {AUX_W{1'b0}};
                level_d = 1'b1;
                line_d  = nrzi_sym(1'b1);
            end
        endcase
    end

    // State, timer and line registers with synchronous reset to idle J.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ones_q  <= {ONES_W{1'b0}};
            aux_q   <= {AUX_W{1'b0}};
            level_q <= 1'b1;
            line_q  <= nrzi_sym(1'b1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ones_q  <= ones_d;
            aux_q   <= aux_d;
            level_q <= level_d;
            line_q  <= line_d;
        end
    end

    // A reset cycle must not report a consumed bit or an underrun.
    assign tx_ready    = ready_s & ~rst;
    assign tx_underrun = underrun_s & ~rst;
    assign busy        = (state_q != ST_IDLE);
    assign dplus_out   = line_q[1];
    assign dminus_out  = line_q[0];

endmodule

// File: tb/tb_usb_line_encoder.sv
module tb_usb_line_encoder;

    localparam int C    = 4;
    localparam int LIM  = 6;
    localparam int SE0B = 2;
    localparam logic [1:0] SYM_J   = 2'b10;
    localparam logic [1:0] SYM_K   = 2'b01;
    localparam logic [1:0] SYM_SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst;
    logic tx_bit, tx_valid, tx_last;
    logic tx_ready, tx_underrun, busy, dplus_out, dminus_out;
    logic ls_bit, ls_valid, ls_last;
    logic ls_ready, ls_underrun, ls_busy, ls_dp, ls_dm;

    int vectors = 0;
    int miscompares = 0;
    int ready_cnt = 0;
    int underrun_cnt = 0;
    logic [1:0] exp_q[$];
    logic payload[$];

    always #5 clk = ~clk;

    usb_line_encoder #(.CLKS_PER_BIT(C), .STUFF_LIMIT(LIM), .EOP_SE0_BITS(SE0B), .LOW_SPEED(1'b0)) dut (
        .clk(clk), .rst(rst), .tx_bit(tx_bit), .tx_valid(tx_valid), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_underrun(tx_underrun), .busy(busy),
        .dplus_out(dplus_out), .dminus_out(dminus_out)
    );

    usb_line_encoder #(.CLKS_PER_BIT(1), .STUFF_LIMIT(LIM), .EOP_SE0_BITS(SE0B), .LOW_SPEED(1'b1)) u_ls (
        .clk(clk), .rst(rst), .tx_bit(ls_bit), .tx_valid(ls_valid), .tx_last(ls_last),
        .tx_ready(ls_ready), .tx_underrun(ls_underrun), .busy(ls_busy),
        .dplus_out(ls_dp), .dminus_out(ls_dm)
    );

    // Handshake pulse monitor for the full-speed instance.
    always @(negedge clk) begin
        if (tx_ready === 1'b1) ready_cnt++;
        if (tx_underrun === 1'b1) underrun_cnt++;
    end

    function automatic logic [1:0] sym(input logic lvl);
        return lvl ? SYM_J : SYM_K;
    endfunction

    task automatic set_payload(input logic [15:0] bits, input int n);
        payload.delete();
        for (int i = 0; i < n; i++) payload.push_back(bits[i]);
    endtask

    // Reference line: NRZI from J, stuffing after LIM ones, SE0 x SE0B, J.
    task automatic build_expected(input int n_send);
        logic lvl;
        int ones;
        exp_q.delete();
        lvl = 1'b1;
        ones = 0;
`ifdef USB_ENC_SYNC_GEN_EN
        for (int i = 0; i < 7; i++) begin
            lvl = ~lvl;
            exp_q.push_back(sym(lvl));
        end
        exp_q.push_back(sym(lvl));
        ones = 1;
`endif
        for (int i = 0; i < n_send; i++) begin
            if (payload[i]) ones++;
            else begin
                ones = 0;
                lvl = ~lvl;
            end
            exp_q.push_back(sym(lvl));
            if (ones == LIM) begin
                lvl = ~lvl;
                ones = 0;
                exp_q.push_back(sym(lvl));
            end
        end
        for (int i = 0; i < SE0B; i++) exp_q.push_back(SYM_SE0);
        exp_q.push_back(SYM_J);
    endtask

    // Sends n_send payload bits (tx_last on the final one if use_last, else underrun).
    task automatic run_packet(input string name, input int n_send, input bit use_last);
        int idx;
        int r0;
        int u0;
        logic rdy;
        logic [1:0] exp_sym;
        build_expected(n_send);
        r0 = ready_cnt;
        u0 = underrun_cnt;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_bit = payload[0];
        tx_last = use_last && (n_send == 1);
        fork
            begin : drive
                idx = 0;
                for (int cyc = 0; cyc < 2000 && idx < n_send; cyc++) begin
                    @(negedge clk);
                    rdy = tx_ready;
                    @(posedge clk);
                    #1;
                    if (rdy === 1'b1) begin
                        idx++;
                        if (idx < n_send) begin
                            tx_bit = payload[idx];
                            tx_last = use_last && (idx == n_send - 1);
                        end else begin
                            tx_valid = 1'b0;
                            tx_last = 1'b0;
                            tx_bit = 1'b0;
                        end
                    end
                end
                vectors++;
                if (idx != n_send) begin
                    miscompares++;
                    $display("FAIL %s handshake timeout: consumed %0d required %0d", name, idx, n_send);
                end
            end
            begin : check
                @(posedge clk);
                #2;
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy after start: got %b required 1", name, busy);
                end
                for (int k = 1; exp_q.size() > 0; k++) begin
                    repeat (C) @(posedge clk);
                    #2;
                    exp_sym = exp_q.pop_front();
                    vectors++;
                    if ({dplus_out, dminus_out} !== exp_sym) begin
                        miscompares++;
                        $display("FAIL %s line symbol %0d: got %b required %b", name, k, {dplus_out, dminus_out}, exp_sym);
                    end
                end
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy during EOP J: got %b required 1", name, busy);
                end
                repeat (C) @(posedge clk);
                #2;
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s busy after EOP: got %b required 0", name, busy);
                end
            end
        join
        tx_valid = 1'b0;
        tx_last = 1'b0;
        vectors++;
        if (ready_cnt - r0 != n_send) begin
            miscompares++;
            $display("FAIL %s tx_ready pulses: got %0d required %0d", name, ready_cnt - r0, n_send);
        end
        vectors++;
        if (underrun_cnt - u0 != (use_last ? 0 : 1)) begin
            miscompares++;
            $display("FAIL %s tx_underrun cycles: got %0d required %0d", name, underrun_cnt - u0, use_last ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if ({dplus_out, dminus_out, busy, tx_ready, tx_underrun} !== 5'b10000) begin
                miscompares++;
                $display("FAIL reset idle cycle %0d: got %b required 10000", i,
                         {dplus_out, dminus_out, busy, tx_ready, tx_underrun});
            end
        end
        vectors++;
        if ({ls_dp, ls_dm, ls_busy, ls_ready} !== 4'b0100) begin
            miscompares++;
            $display("FAIL reset low-speed idle: got %b required 0100", {ls_dp, ls_dm, ls_busy, ls_ready});
        end
    endtask

    task automatic test_zeros();
        set_payload(16'h0000, 8);
        run_packet("zeros", 8, 1'b1);
    endtask

    task automatic test_stuff_mid();
        set_payload(16'h007F, 8);
        run_packet("stuff_mid", 8, 1'b1);
    endtask

    task automatic test_stuff_last();
        set_payload(16'h007E, 7);
        run_packet("stuff_last", 7, 1'b1);
    endtask

    task automatic test_underrun();
        set_payload(16'h0002, 3);
        run_packet("underrun", 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        set_payload(16'h00A5, 8);
        run_packet("b2b_first", 8, 1'b1);
        set_payload(16'h003C, 8);
        run_packet("b2b_second", 8, 1'b1);
    endtask

    task automatic test_reset_mid();
        int got;
        int n;
        int u0;
        set_payload(16'h0000, 8);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_bit = 1'b0;
        tx_last = 1'b0;
        got = 0;
        n = 0;
        while (got < 3 && n < 200) begin
            @(negedge clk);
            if (tx_ready === 1'b1) got++;
            n++;
        end
        vectors++;
        if (got != 3) begin
            miscompares++;
            $display("FAIL reset_mid handshake: got %0d required 3", got);
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (C - 1) @(posedge clk);
        #1 rst = 1'b1;
        u0 = underrun_cnt;
        @(negedge clk);
        vectors++;
        if (tx_underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid underrun during reset: got %b required 0", tx_underrun);
        end
        @(posedge clk);
        #2;
        vectors++;
        if ({dplus_out, dminus_out, busy} !== 3'b100) begin
            miscompares++;
            $display("FAIL reset_mid line after reset: got %b required 100", {dplus_out, dminus_out, busy});
        end
        rst = 1'b0;
        repeat (3 * C) @(posedge clk);
        #2;
        vectors++;
        if ({dplus_out, dminus_out, busy, underrun_cnt - u0 == 0} !== 4'b1001) begin
            miscompares++;
            $display("FAIL reset_mid idle after reset: got %b required 1001",
                     {dplus_out, dminus_out, busy, underrun_cnt - u0 == 0});
        end
    endtask

    task automatic test_low_speed();
        int n;
        logic [1:0] exp_ls;
`ifdef USB_ENC_SYNC_GEN_EN
        exp_ls = 2'b01;
`else
        exp_ls = 2'b10;
`endif
        @(negedge clk);
        ls_valid = 1'b1;
        ls_bit = 1'b0;
        ls_last = 1'b0;
        n = 0;
        while (ls_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (ls_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL low_speed first ready: got %b required 1", ls_ready);
        end
        @(posedge clk);
        #1;
        ls_bit = 1'b1;
        ls_last = 1'b1;
        #1;
        vectors++;
        if ({ls_dp, ls_dm} !== exp_ls) begin
            miscompares++;
            $display("FAIL low_speed line after bit 0: got %b required %b", {ls_dp, ls_dm}, exp_ls);
        end
        @(negedge clk);
        vectors++;
        if (ls_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL low_speed consecutive ready: got %b required 1", ls_ready);
        end
        @(posedge clk);
        #1;
        ls_valid = 1'b0;
        ls_last = 1'b0;
        #1;
        vectors++;
        if ({ls_dp, ls_dm, ls_busy} !== {exp_ls, 1'b1}) begin
            miscompares++;
            $display("FAIL low_speed line after bit 1: got %b required %b", {ls_dp, ls_dm, ls_busy}, {exp_ls, 1'b1});
        end
        @(posedge clk);
        #2;
        vectors++;
        if ({ls_dp, ls_dm} !== SYM_SE0) begin
            miscompares++;
            $display("FAIL low_speed EOP SE0: got %b required 00", {ls_dp, ls_dm});
        end
        n = 0;
        while (ls_busy !== 1'b0 && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        vectors++;
        if ({ls_dp, ls_dm, ls_busy} !== 3'b010) begin
            miscompares++;
            $display("FAIL low_speed idle after EOP: got %b required 010", {ls_dp, ls_dm, ls_busy});
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_bit = 1'b0;
        tx_valid = 1'b0;
        tx_last = 1'b0;
        ls_bit = 1'b0;
        ls_valid = 1'b0;
        ls_last = 1'b0;
        test_reset();
        test_zeros();
        test_stuff_mid();
        test_stuff_last();
        test_underrun();
        test_back_to_back();
        test_reset_mid();
        test_low_speed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
